// File: rtl/mbist_march_ctrl.sv
// March C- MBIST engine driving a single-port synchronous memory and checking its registered read data.
// Optional MBIST_FAIL_STOP_EN: stop the test and report done on the first mismatch.
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CAPACITY   = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_syndrome,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BG0       = '0;
  localparam logic [DATA_WIDTH-1:0] BG1       = '1;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_M0    = 4'd1,
    S_M1    = 4'd2,
    S_M2    = 4'd3,
    S_M3    = 4'd4,
    S_M4    = 4'd5,
    S_M5    = 4'd6,
    S_FLUSH = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_syn_q, fail_syn_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  // Two-stage compare pipeline: stage 0 = read issued, stage 1 = rdata valid next cycle.
  logic                  cmp0_v_q, cmp0_v_d;
  logic [DATA_WIDTH-1:0] cmp0_exp_q, cmp0_exp_d;
  logic [ADDR_WIDTH-1:0] cmp0_addr_q, cmp0_addr_d;
  logic                  cmp1_v_q, cmp1_v_d;
  logic [DATA_WIDTH-1:0] cmp1_exp_q, cmp1_exp_d;
  logic [ADDR_WIDTH-1:0] cmp1_addr_q, cmp1_addr_d;

  logic mismatch_c;
  logic last_c;
  logic op_active_c;

  function automatic logic elem_down(input state_e s);
    return (s == S_M3) || (s == S_M4);
  endfunction

  function automatic logic elem_pair(input state_e s);
    return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4);
  endfunction

  function automatic logic elem_op(input state_e s);
    return (s == S_M0) || (s == S_M5) || elem_pair(s);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_bg(input state_e s);
    return ((s == S_M2) || (s == S_M4)) ? BG1 : BG0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] write_bg(input state_e s);
    return ((s == S_M1) || (s == S_M3)) ? BG1 : BG0;
  endfunction

  function automatic state_e next_elem(input state_e s);
    case (s)
      S_M0:    return S_M1;
      S_M1:    return S_M2;
      S_M2:    return S_M3;
      S_M3:    return S_M4;
      S_M4:    return S_M5;
      default: return S_FLUSH;
    endcase
  endfunction

  // Sequencing, compare and next-output computation.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_syn_d  = fail_syn_q;
    cmp1_v_d    = cmp0_v_q;
    cmp1_exp_d  = cmp0_exp_q;
    cmp1_addr_d = cmp0_addr_q;

    mismatch_c = cmp1_v_q && (rdata != cmp1_exp_q);
    last_c     = elem_down(state_q) ? (addr_q == '0) : (addr_q == LAST_ADDR);

    if (mismatch_c) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        fail_addr_d = cmp1_addr_q;
        fail_syn_d  = rdata ^ cmp1_exp_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_M0;
          addr_d      = '0;
          phase_d     = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_syn_d  = '0;
        end
      end
      S_M0, S_M5: begin
        if (last_c) begin
          state_d = next_elem(state_q);
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_M1, S_M2, S_M3, S_M4: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (last_c) begin
            state_d = next_elem(state_q);
            addr_d  = elem_down(next_elem(state_q)) ? LAST_ADDR : '0;
          end else if (elem_down(state_q)) begin
            addr_d = addr_q - ADDR_ONE;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
      end
      S_FLUSH: begin
        // The last read's compare lands on this edge once stage 0 has drained.
        if (!cmp0_v_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef MBIST_FAIL_STOP_EN
    if (mismatch_c && !fail_q) begin
      state_d  = S_DONE;
      addr_d   = '0;
      phase_d  = 1'b0;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      cmp1_v_d = 1'b0;
    end
`endif

    op_active_c = elem_op(state_d);
    wr_d        = op_active_c && ((state_d == S_M0) || (elem_pair(state_d) && phase_d));
    address_d   = op_active_c ? addr_d : '0;
    wdata_d     = wr_d ? write_bg(state_d) : '0;
    cmp0_v_d    = op_active_c && !wr_d;
    cmp0_exp_d  = read_bg(state_d);
    cmp0_addr_d = addr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_syn_q  <= '0;
      wr_q        <= 1'b0;
      address_q   <= '0;
      wdata_q     <= '0;
      cmp0_v_q    <= 1'b0;
      cmp0_exp_q  <= '0;
      cmp0_addr_q <= '0;
      cmp1_v_q    <= 1'b0;
      cmp1_exp_q  <= '0;
      cmp1_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_syn_q  <= fail_syn_d;
      wr_q        <= wr_d;
      address_q   <= address_d;
      wdata_q     <= wdata_d;
      cmp0_v_q    <= cmp0_v_d;
      cmp0_exp_q  <= cmp0_exp_d;
      cmp0_addr_q <= cmp0_addr_d;
      cmp1_v_q    <= cmp1_v_d;
      cmp1_exp_q  <= cmp1_exp_d;
      cmp1_addr_q <= cmp1_addr_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign fail          = fail_q;
  assign fail_addr     = fail_addr_q;
  assign fail_syndrome = fail_syn_q;
  assign write_read    = wr_q;
  assign address       = address_q;
  assign wdata         = wdata_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Scoreboard bench for mbist_march_ctrl: a behavioural memory with injectable faults, an expected
// per-cycle operation queue and a per-run result queue checked by an independent monitor.
module tb_mbist_march_ctrl;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 4;
  localparam int unsigned CAP = 15;
  localparam int unsigned N   = CAP + 1;

`ifdef MBIST_FAIL_STOP_EN
  localparam int SA_STOP = 32;
  localparam int CF_STOP = 60;
`else
  localparam int SA_STOP = 0;
  localparam int CF_STOP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail, write_read;
  logic [AW-1:0] fail_addr, address;
  logic [DW-1:0] fail_syndrome, wdata;
  logic [DW-1:0] rdata = '0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_syndrome(fail_syndrome), .write_read(write_read),
    .address(address), .wdata(wdata), .rdata(rdata)
  );

  typedef struct {bit marker; bit wr; logic [AW-1:0] a; logic [DW-1:0] d;} op_t;
  typedef struct {bit f; logic [AW-1:0] a; logic [DW-1:0] s;} res_t;

  op_t  op_q[$];
  res_t res_q[$];
  int   tests = 0;
  int   fails = 0;

  // Memory model. Stuck-at-1 on bit 5 of address 7; coupling fault on bit 6 of address 5, whose
  // write is suppressed when bit 6 of neighbours {6,4,7,8} reads 4'b0100.
  logic [DW-1:0] mem [N];
  bit            sa_en = 1'b0;
  bit            cf_en = 1'b0;
  bit            preload = 1'b0;

  function automatic logic [DW-1:0] mem_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] v;
    logic [3:0]    nb;
    v = d;
    if (sa_en && a == 4'd7) v = d | 8'h20;
    if (cf_en && a == 4'd5) begin
      nb = {mem[6][6], mem[4][6], mem[7][6], mem[8][6]};
      if (nb == 4'b0100) v[6] = mem[5][6];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < int'(N); i++) mem[i] <= 8'h5A;
    end else if (write_read) begin
      mem[address] <= mem_write(address, wdata);
    end else begin
      rdata <= mem[address] | ((sa_en && address == 4'd7) ? 8'h20 : 8'h00);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic op_t mk(input bit wr, input int a, input logic [DW-1:0] d);
    op_t o;
    o.marker = 1'b0;
    o.wr     = wr;
    o.a      = AW'(a);
    o.d      = d;
    return o;
  endfunction

  // Expected per-busy-cycle outputs of one March C- run, optionally truncated.
  task automatic push_run(input int stop_after);
    op_t run[$];
    op_t m;
    for (int a = 0; a <= int'(CAP); a++) run.push_back(mk(1'b1, a, 8'h00));
    for (int a = 0; a <= int'(CAP); a++) begin
      run.push_back(mk(1'b0, a, 8'h00)); run.push_back(mk(1'b1, a, 8'hFF));
    end
    for (int a = 0; a <= int'(CAP); a++) begin
      run.push_back(mk(1'b0, a, 8'h00)); run.push_back(mk(1'b1, a, 8'h00));
    end
    for (int a = int'(CAP); a >= 0; a--) begin
      run.push_back(mk(1'b0, a, 8'h00)); run.push_back(mk(1'b1, a, 8'hFF));
    end
    for (int a = int'(CAP); a >= 0; a--) begin
      run.push_back(mk(1'b0, a, 8'h00)); run.push_back(mk(1'b1, a, 8'h00));
    end
    for (int a = 0; a <= int'(CAP); a++) run.push_back(mk(1'b0, a, 8'h00));
    run.push_back(mk(1'b0, 0, 8'h00));
    if (stop_after > 0) while (run.size() > stop_after) void'(run.pop_back());
    foreach (run[i]) op_q.push_back(run[i]);
    m = mk(1'b0, 0, 8'h00);
    m.marker = 1'b1;
    op_q.push_back(m);
  endtask

  task automatic push_res(input bit f, input int a, input logic [DW-1:0] s);
    res_t r;
    r.f = f;
    r.a = AW'(a);
    r.s = s;
    res_q.push_back(r);
  endtask

  // Monitor: one expected op per busy cycle, one result per rising done.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        if (op_q.size() == 0 || op_q[0].marker) begin
          tests++; fails++;
          $display("FAIL op_overrun: busy with no expected operation left (t=%0t)", $time);
        end else begin
          op_t e;
          e = op_q.pop_front();
          check("op_write_read", 32'(write_read), 32'(e.wr));
          check("op_address", 32'(address), 32'(e.a));
          check("op_wdata", 32'(wdata), 32'(e.d));
        end
      end else begin
        check("idle_write_read", 32'(write_read), 32'd0);
        check("idle_address", 32'(address), 32'd0);
      end
      if (done && !done_prev) begin
        tests++;
        if (op_q.size() > 0 && op_q[0].marker) begin
          void'(op_q.pop_front());
        end else begin
          fails++;
          $display("FAIL op_count: done rose with %0d expected ops pending (t=%0t)", op_q.size(), $time);
        end
        check("done_busy", 32'(busy), 32'd0);
        if (res_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL result_unexpected: done rose with no expected result (t=%0t)", $time);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("res_fail", 32'(fail), 32'(r.f));
          check("res_fail_addr", 32'(fail_addr), 32'(r.a));
          check("res_fail_syndrome", 32'(fail_syndrome), 32'(r.s));
        end
      end
    end
    done_prev <= done;
  end

  task automatic start_pulse();
    @(negedge clk) preload = 1'b1;
    @(negedge clk) preload = 1'b0;
    start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) return;
    end
    tests++; fails++;
    $display("FAIL %s_timeout: done not seen within 400 cycles", tag);
  endtask

  initial begin
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fail", 32'(fail), 32'd0);
    check("rst_write_read", 32'(write_read), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fault-free run.
    push_run(0); push_res(1'b0, 0, 8'h00);
    start_pulse(); wait_done("clean");

    // Stuck-at-1, bit 5 of address 7: first caught by the M1 r0 at address 7.
    sa_en = 1'b1;
    push_run(SA_STOP); push_res(1'b1, 7, 8'h20);
    start_pulse(); wait_done("stuck_at");
    sa_en = 1'b0;

    // Coupling fault at address 5: the M1 w1 is lost, first caught by the M2 r1.
    cf_en = 1'b1;
    push_run(CF_STOP); push_res(1'b1, 5, 8'h40);
    start_pulse(); wait_done("coupling");
    cf_en = 1'b0;

    // Asynchronous reset in the middle of M3, then a clean rerun.
    push_run(0);
    start_pulse();
    repeat (88) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_write_read", 32'(write_read), 32'd0);
    check("midrst_address", 32'(address), 32'd0);
    check("midrst_wdata", 32'(wdata), 32'd0);
    op_q.delete(); res_q.delete();
    @(negedge clk) rst_n = 1'b1;
    push_run(0); push_res(1'b0, 0, 8'h00);
    start_pulse(); wait_done("after_reset");

    // Start held high: faulty run, then immediate restart from DONE on a healed memory.
    sa_en = 1'b1;
    push_run(SA_STOP); push_res(1'b1, 7, 8'h20);
    push_run(0); push_res(1'b0, 0, 8'h00);
    @(negedge clk) start = 1'b1;
    wait_done("held_first");
    sa_en = 1'b0;
    @(negedge clk);
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_fail", 32'(fail), 32'd0);
    start = 1'b0;
    wait_done("held_second");

    repeat (4) @(negedge clk);
    check("ops_drained", 32'(op_q.size()), 32'd0);
    check("results_drained", 32'(res_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
# mbist_march_ctrl

- March C- BIST engine: the initiator side of the single-port synchronous memory interface used by the fault memory models.
- Drives `write_read`, `address` and `wdata`, and checks the registered `rdata` against expected background data.
- Records the first failing address and bit syndrome, and reports completion to the top-level MBIST wrapper.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: memory word width.
- `ADDR_WIDTH`, default 4: memory address width.
- `CAPACITY`, default 15: highest address tested. N = `CAPACITY`+1 words, all tested from address 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: begin a test. Sampled only in IDLE or DONE.
- `busy` out 1: test in progress.
- `done` out 1: test finished. Holds high until the next accepted `start`.
- `fail` out 1: sticky mismatch flag.
- `fail_addr` out `ADDR_WIDTH`: address of the first mismatch.
- `fail_syndrome` out `DATA_WIDTH`: `rdata` XOR expected at the first mismatch.
- `write_read` out 1: 1 = write, 0 = read (to memory).
- `address` out `ADDR_WIDTH`: memory address.
- `wdata` out `DATA_WIDTH`: memory write data.
- `rdata` in `DATA_WIDTH`: memory read data. The memory registers it at the edge after the read is presented.

## Operation

- States: IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE. Element sequence:
  - M0 up(w0)
  - M1 up(r0,w1)
  - M2 up(r1,w0)
  - M3 down(r0,w1)
  - M4 down(r1,w0)
  - M5 up(r0)
- Data and address conventions:
  - Background 0 = all zeros; background 1 = all ones.
  - "up" = 0 to `CAPACITY`; "down" = `CAPACITY` to 0.
- Two-operation elements (M1 to M4):
  - Each address takes 2 cycles: read phase (`write_read`=0), then write phase (`write_read`=1) at the same address.
  - The address then advances.
- Single-operation elements (M0, M5) take 1 cycle per address.
- Element transition: on the last address of an element, the next element starts the following cycle at its own start address.
- Compare pipeline:
  - Each read registers a compare-valid flag plus the expected word and address.
  - One cycle later `rdata` is valid. The compare happens on the edge after that, two edges after the read is driven.
- On mismatch:
  - `fail` is set.
  - If `fail` was previously 0, `fail_addr` and `fail_syndrome` are captured.
  - Later mismatches never overwrite them.
- FLUSH: entered after the last M5 read. It waits for the final compare, then moves to DONE.
- Accepting `start` in IDLE or DONE:
  - clears `fail`, `fail_addr`, `fail_syndrome` and `done`;
  - sets `busy`;
  - enters M0.
- `start` while `busy` is ignored.
- Address arithmetic never exceeds the `CAPACITY`..0 range; no wrap into untested addresses.
- Outputs are all registered.
- Outside M0 to M5, outputs are `write_read`=0, `address`=0, `wdata`=0.

## Timing

- Reset values: `busy`, `done`, `fail`, `fail_addr`, `fail_syndrome`, `write_read`, `address` and `wdata` are all 0. State is IDLE.
- Reset is asynchronous and may arrive mid-test. The engine returns to IDLE immediately and any pending compare is discarded.
- If `start` is sampled at edge k, the first M0 write is driven from edge k.
- The last M5 read is driven at edge k+10N-1.
- `done`=1 and `busy`=0 from edge k+10N+1. Total 10N+1 cycles.
- In every write cycle, `wdata` is stable with `write_read`=1 for exactly one cycle per operation.

## Configuration

- `MBIST_FAIL_STOP_EN` defined:
  - On the first mismatch, the engine goes to DONE at that compare edge. No further memory operation is issued after that edge.
  - `address` holds 0 and `write_read` holds 0.
- `MBIST_FAIL_STOP_EN` undefined:
  - The test always runs all six elements.
  - `done` timing is fixed at 10N+1 cycles regardless of failures.

## Test plan

- Fault-free memory, N=16, `start` pulse:
  - `busy` for 161 cycles, then `done`=1, `fail`=0.
  - Exactly 160 memory operations, all addresses 0 to 15 in the correct up/down order.
- Stuck-at-1 on bit 5 of address 7:
  - `fail`=1, `fail_addr`=7, `fail_syndrome`=0x20.
  - First mismatch is in M1 (r0).
- Coupling fault, as in the fault model: bit 6 of address W is not written when the neighbour pattern is 4'b0100.
  - Result: `fail`=1, `fail_addr`=W, `fail_syndrome`=0x40.
- With `MBIST_FAIL_STOP_EN`, stuck-at-1 on address 7:
  - `done` rises at the compare edge of the M1 read at address 7.
  - No memory write occurs after that edge.
- `rst_n` low during M3:
  - All outputs 0 asynchronously.
  - A subsequent `start` completes a full clean 161-cycle run.
- `start` held high throughout a run:
  - Ignored while `busy`.
  - Restarts from DONE on the next edge, clearing `done` and `fail`.
